game_sequencer: RTL and testbench
=================================

# game_sequencer

Top-level game controller that sequences the per-level claw/loot state machine through a complete game: title screen, level load, timed play, level result, and final win/game-over screens. It drives the level state machine's `start_level`, `goal` and `timer_ended` inputs. It also owns the per-level countdown timer (derived from `startOfFrame`) and accumulates the total score across levels. It consumes `level_ended` and the level score from the level state machine, plus the player's enter key.

## Interface
Parameters:
- `NUM_LEVELS`, 3: number of levels; legal range 1..8.
- `LEVEL_TIME`, 60: seconds per level; legal range 1..127.
- `FRAMES_PER_SEC`, 30: `startOfFrame` pulses per second; legal range 1..63.
- `GOAL_BASE`, 20: goal of level 0.
- `GOAL_STEP`, 20: goal increment per level. `GOAL_BASE + GOAL_STEP*(NUM_LEVELS-1)` must be < 1024.

Ports:
- `clk`, in, 1: single clock.
- `reset`, in, 1: asynchronous, active-high.
- `startOfFrame`, in, 1: one-cycle pulse at each frame start.
- `is_enter_pressed`, in, 1: level signal from the keyboard decoder.
- `level_ended`, in, 1: level state machine has finished its level (level signal).
- `level_score`, in, 10: score of the current level.
- `start_level`, out, 1: one-cycle pulse that starts a level.
- `goal`, out, 10: goal for the current level.
- `timer_ended`, out, 1: countdown has expired. Stays high until PLAY is left.
- `seconds_left`, out, 7: remaining seconds, for the HUD.
- `level_num`, out, 3: current level, 0-based.
- `total_score`, out, 12: accumulated score, saturating.
- `level_clear`, out, 1: high while in TITLE. The integrator ORs it into the level state machine's reset.
- `game_state`, out, 3: encoded state for the screen mux: TITLE=0, LOAD=1, PLAY=2, RESULT=3, GAME_OVER=4, WIN=5.

## Operation
- **Enter edge detection:** `enter_edge = is_enter_pressed & ~enter_q`. `enter_q` is registered and resets to 1, so a key held through reset produces no edge. Only `enter_edge` is used as a command.
- **TITLE:**
  - Asserts `level_clear`.
  - On `enter_edge`: `level_num`←0, `total_score`←0, go to LOAD.
- **LOAD (exactly one cycle):**
  - `start_level`=1.
  - `goal`←`GOAL_BASE + GOAL_STEP*level_num`.
  - `seconds_left`←`LEVEL_TIME`, frame counter←0.
  - Go to PLAY.
- **PLAY:**
  - Each `startOfFrame` increments the frame counter.
  - On the pulse where the counter equals `FRAMES_PER_SEC-1`: counter←0 and `seconds_left`←`seconds_left-1`. Counting stops at 0; no underflow.
  - `timer_ended` is registered, =1 whenever in PLAY with `seconds_left`==0.
  - On `level_ended`: latch `pass = (level_score >= goal)`, latch `level_score`, go to RESULT.
- **RESULT:** waits for `enter_edge`, then:
  - If `pass` and `level_num < NUM_LEVELS-1`: add the latched score to `total_score`, `level_num`+1, go to LOAD.
  - If `pass` and last level: add the score, go to WIN.
  - If not `pass`: go to GAME_OVER.
- **GAME_OVER / WIN:** on `enter_edge`, go to TITLE.
- **Score arithmetic:** `total_score` is 12-bit and saturates at 4095; no wrap.
- **Priority and boundary rules:**
  - `reset` overrides everything. A reset mid-level returns to TITLE immediately.
  - `level_ended` and `enter_edge` in the same PLAY cycle: go to RESULT; that edge is consumed and ignored. A new press is required.
  - `enter_edge` in LOAD or PLAY is ignored.
  - `startOfFrame` outside PLAY is ignored; the frame counter holds.
  - `level_ended` outside PLAY is ignored.
  - An unknown state encoding goes to TITLE.

## Timing
- **Reset values:**
  - `game_state`=TITLE, `level_clear`=1.
  - `start_level`=0, `timer_ended`=0.
  - `seconds_left`=0, `level_num`=0, `total_score`=0.
  - `goal`=`GOAL_BASE`, `enter_q`=1.
- All outputs are registered or are decodes of registered state; none is combinational from inputs.
- The cycle after `enter_edge` in TITLE, `game_state`=LOAD and `start_level`=1 for that single cycle. The next cycle is PLAY.
- `seconds_left` decrements on the clock after the qualifying `startOfFrame`.
- `timer_ended` rises 1 cycle after `seconds_left` reaches 0.
- `game_state` leaves PLAY 1 cycle after `level_ended` is sampled high. `timer_ended` drops in the same cycle.
- A full level lasts `LEVEL_TIME*FRAMES_PER_SEC` frames from LOAD to `timer_ended`.

## Test plan
Scenarios use `FRAMES_PER_SEC`=2, `LEVEL_TIME`=3, `NUM_LEVELS`=2, `GOAL_BASE`=20, `GOAL_STEP`=20.
- **Reset and start:** reset with enter held, release, then press.
  - No LOAD while enter is held.
  - After the press: one-cycle `start_level`, `goal`=20, `seconds_left`=3.
- **Countdown:** 6 `startOfFrame` pulses in PLAY.
  - `seconds_left` steps 3→2→1→0, one step per 2 pulses.
  - `timer_ended`=1 one cycle after reaching 0; further pulses leave it at 0.
- **Pass then win:**
  - `level_score`=25 and `level_ended`, then press: `total_score`=25, `level_num`=1, `goal`=40.
  - Then `level_score`=40 and a press: WIN with `total_score`=65.
  - A further press: TITLE, with `level_clear`=1.
- **Fail:** `level_score`=19 in level 0, then press → GAME_OVER, `total_score` stays 0.
- **Simultaneous events:** `level_ended` and a new enter edge in the same cycle → RESULT only. A second press is required to advance.
- **Saturation and mid-operation reset:**
  - Preload near the limit by forcing `level_score`=1023 across many levels with a large `NUM_LEVELS`: `total_score` clamps at 4095.
  - Assert `reset` in PLAY: next cycle TITLE, all outputs at their reset values.

Source files
------------

// File: rtl/game_sequencer.sv
// game_sequencer: top-level game controller sequencing title, level load, timed play,
// level result and final win/game-over screens around the per-level claw/loot FSM.
// Inputs : clk, reset (async, active-high), startOfFrame (1-cycle pulse),
//          is_enter_pressed (level), level_ended (level), level_score[9:0]
// Outputs: start_level (pulse in LOAD), goal[9:0], timer_ended, seconds_left[6:0],
//          level_num[2:0], total_score[11:0] (saturating), level_clear (in TITLE),
//          game_state[2:0] (TITLE=0 LOAD=1 PLAY=2 RESULT=3 GAME_OVER=4 WIN=5)
module game_sequencer #(
  parameter int NUM_LEVELS     = 3,
  parameter int LEVEL_TIME     = 60,
  parameter int FRAMES_PER_SEC = 30,
  parameter int GOAL_BASE      = 20,
  parameter int GOAL_STEP      = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       startOfFrame,
  input  logic       is_enter_pressed,
  input  logic       level_ended,
  input  logic [9:0] level_score,
  output logic       start_level,
  output logic [9:0] goal,
  output logic       timer_ended,
  output logic [6:0] seconds_left,
  output logic [2:0] level_num,
  output logic [11:0] total_score,
  output logic       level_clear,
  output logic [2:0] game_state
);
  typedef enum logic [2:0] {
    TITLE     = 3'd0,
    LOAD      = 3'd1,
    PLAY      = 3'd2,
    RESULT    = 3'd3,
    GAME_OVER = 3'd4,
    WIN       = 3'd5
  } state_t;
  state_t      r_state, w_next;
  logic        r_enter_q, r_pass, r_timer_ended;
  logic [5:0]  r_frame;
  logic [6:0]  r_seconds;
  logic [2:0]  r_level;
  logic [9:0]  r_goal, r_score;
  logic [11:0] r_total;
  logic [12:0] w_sum;
  logic        w_enter_edge, w_last, w_sec_tick;
  // enter_q resets high so a key held through reset is not seen as a press
  assign w_enter_edge = is_enter_pressed & ~r_enter_q;
  assign w_last       = int'(r_level) >= NUM_LEVELS - 1;
  assign w_sec_tick   = startOfFrame && int'(r_frame) == FRAMES_PER_SEC - 1;
  assign w_sum        = {1'b0, r_total} + {3'b000, r_score};
  assign start_level  = r_state == LOAD;
  assign level_clear  = r_state == TITLE;
  assign game_state   = r_state;
  assign goal         = r_goal;
  assign timer_ended  = r_timer_ended;
  assign seconds_left = r_seconds;
  assign level_num    = r_level;
  assign total_score  = r_total;
  always_comb begin
    w_next = r_state;
    case (r_state)
      TITLE:          if (w_enter_edge) w_next = LOAD;
      LOAD:           w_next = PLAY;
      PLAY:           if (level_ended) w_next = RESULT;
      RESULT:         if (w_enter_edge) w_next = !r_pass ? GAME_OVER : w_last ? WIN : LOAD;
      GAME_OVER, WIN: if (w_enter_edge) w_next = TITLE;
      default:        w_next = TITLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= TITLE;
      r_enter_q     <= 1'b1;
      r_pass        <= 1'b0;
      r_timer_ended <= 1'b0;
      r_frame       <= '0;
      r_seconds     <= '0;
      r_level       <= '0;
      r_goal        <= 10'(GOAL_BASE);
      r_score       <= '0;
      r_total       <= '0;
    end else begin
      r_state   <= w_next;
      r_enter_q <= is_enter_pressed;
      // cleared in the same cycle PLAY is left
      r_timer_ended <= r_state == PLAY && w_next == PLAY && r_seconds == '0;
      if (r_state == TITLE && w_enter_edge) begin
        r_level <= '0;
        r_total <= '0;
      end
      if (r_state == LOAD) begin
        r_goal    <= 10'(GOAL_BASE + GOAL_STEP * int'(r_level));
        r_seconds <= 7'(LEVEL_TIME);
        r_frame   <= '0;
      end
      if (r_state == PLAY && startOfFrame)
        r_frame <= w_sec_tick ? '0 : r_frame + 6'd1;
      if (r_state == PLAY && w_sec_tick && r_seconds != '0)
        r_seconds <= r_seconds - 7'd1;
      if (r_state == PLAY && level_ended) begin
        r_pass  <= level_score >= r_goal;
        r_score <= level_score;
      end
      if (r_state == RESULT && w_enter_edge && r_pass) begin
        r_total <= w_sum[12] ? 12'hFFF : w_sum[11:0];
        if (!w_last) r_level <= r_level + 3'd1;
      end
    end
  end
endmodule

// File: tb/tb_game_sequencer.sv
// tb_game_sequencer: directed self-checking bench for game_sequencer.
module tb_game_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1, sof = 1'b0, enter = 1'b1, ended = 1'b0;
  logic [9:0] score = '0;
  logic start_level, timer_ended, level_clear;
  logic [9:0] goal;
  logic [6:0] seconds_left;
  logic [2:0] level_num, game_state;
  logic [11:0] total_score;
  logic reset2 = 1'b1, enter2 = 1'b0, ended2 = 1'b0;
  logic [9:0] score2 = '0;
  logic s_start, s_timer, s_clear;
  logic [9:0] s_goal;
  logic [6:0] s_sec;
  logic [2:0] s_level, s_state;
  logic [11:0] s_total;
  int n = 0, nf = 0;

  always #5 clk = ~clk;

  game_sequencer #(.NUM_LEVELS(2), .LEVEL_TIME(3), .FRAMES_PER_SEC(2), .GOAL_BASE(20), .GOAL_STEP(20)) dut (
    .clk(clk), .reset(reset), .startOfFrame(sof), .is_enter_pressed(enter), .level_ended(ended),
    .level_score(score), .start_level(start_level), .goal(goal), .timer_ended(timer_ended),
    .seconds_left(seconds_left), .level_num(level_num), .total_score(total_score),
    .level_clear(level_clear), .game_state(game_state));

  game_sequencer #(.NUM_LEVELS(8), .LEVEL_TIME(3), .FRAMES_PER_SEC(2), .GOAL_BASE(20), .GOAL_STEP(20)) dut_sat (
    .clk(clk), .reset(reset2), .startOfFrame(sof), .is_enter_pressed(enter2), .level_ended(ended2),
    .level_score(score2), .start_level(s_start), .goal(s_goal), .timer_ended(s_timer),
    .seconds_left(s_sec), .level_num(s_level), .total_score(s_total),
    .level_clear(s_clear), .game_state(s_state));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press();
    enter = 1'b0;
    tick();
    enter = 1'b1;
    tick();
    enter = 1'b0;
  endtask

  task automatic press2();
    enter2 = 1'b0;
    tick();
    enter2 = 1'b1;
    tick();
    enter2 = 1'b0;
  endtask

  task automatic pulse_sof();
    sof = 1'b1;
    tick();
    sof = 1'b0;
    tick();
  endtask

  task automatic check_reset_values(input string tag);
    n++; if (game_state !== 3'd0) begin nf++; $display("FAIL %s state got %0d exp 0", tag, game_state); end
    n++; if (level_clear !== 1'b1) begin nf++; $display("FAIL %s level_clear got %b exp 1", tag, level_clear); end
    n++; if (start_level !== 1'b0) begin nf++; $display("FAIL %s start_level got %b exp 0", tag, start_level); end
    n++; if (timer_ended !== 1'b0) begin nf++; $display("FAIL %s timer_ended got %b exp 0", tag, timer_ended); end
    n++; if (seconds_left !== 7'd0) begin nf++; $display("FAIL %s seconds got %0d exp 0", tag, seconds_left); end
    n++; if (level_num !== 3'd0) begin nf++; $display("FAIL %s level got %0d exp 0", tag, level_num); end
    n++; if (total_score !== 12'd0) begin nf++; $display("FAIL %s total got %0d exp 0", tag, total_score); end
    n++; if (goal !== 10'd20) begin nf++; $display("FAIL %s goal got %0d exp 20", tag, goal); end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    enter = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    check_reset_values("reset");
    tick();
    tick();
    tick();
    n++; if (game_state !== 3'd0) begin nf++; $display("FAIL held_enter state got %0d exp 0", game_state); end
    enter = 1'b0;
    tick();
    enter = 1'b1;
    tick();
    n++; if (game_state !== 3'd1) begin nf++; $display("FAIL start_load state got %0d exp 1", game_state); end
    n++; if (start_level !== 1'b1) begin nf++; $display("FAIL start_pulse got %b exp 1", start_level); end
    enter = 1'b0;
    tick();
    n++; if (game_state !== 3'd2) begin nf++; $display("FAIL start_play state got %0d exp 2", game_state); end
    n++; if (start_level !== 1'b0) begin nf++; $display("FAIL start_pulse_end got %b exp 0", start_level); end
    n++; if (goal !== 10'd20) begin nf++; $display("FAIL start_goal got %0d exp 20", goal); end
    n++; if (seconds_left !== 7'd3) begin nf++; $display("FAIL start_seconds got %0d exp 3", seconds_left); end
  endtask

  task automatic test_countdown();
    for (int i = 1; i <= 5; i++) begin
      pulse_sof();
      n++;
      if (seconds_left !== 7'(3 - i / 2)) begin
        nf++; $display("FAIL countdown_%0d got %0d exp %0d", i, seconds_left, 3 - i / 2);
      end
      n++; if (timer_ended !== 1'b0) begin nf++; $display("FAIL countdown_timer_%0d got %b exp 0", i, timer_ended); end
    end
    sof = 1'b1;
    tick();
    sof = 1'b0;
    n++; if (seconds_left !== 7'd0) begin nf++; $display("FAIL countdown_zero got %0d exp 0", seconds_left); end
    n++; if (timer_ended !== 1'b0) begin nf++; $display("FAIL timer_early got %b exp 0", timer_ended); end
    tick();
    n++; if (timer_ended !== 1'b1) begin nf++; $display("FAIL timer_rise got %b exp 1", timer_ended); end
    pulse_sof();
    pulse_sof();
    n++; if (seconds_left !== 7'd0) begin nf++; $display("FAIL no_underflow got %0d exp 0", seconds_left); end
    n++; if (timer_ended !== 1'b1) begin nf++; $display("FAIL timer_hold got %b exp 1", timer_ended); end
  endtask

  task automatic test_pass_win();
    score = 10'd25;
    ended = 1'b1;
    tick();
    ended = 1'b0;
    n++; if (game_state !== 3'd3) begin nf++; $display("FAIL result_state got %0d exp 3", game_state); end
    n++; if (timer_ended !== 1'b0) begin nf++; $display("FAIL timer_drop got %b exp 0", timer_ended); end
    press();
    n++; if (game_state !== 3'd1) begin nf++; $display("FAIL next_load got %0d exp 1", game_state); end
    n++; if (total_score !== 12'd25) begin nf++; $display("FAIL total_l0 got %0d exp 25", total_score); end
    n++; if (level_num !== 3'd1) begin nf++; $display("FAIL level_l1 got %0d exp 1", level_num); end
    tick();
    n++; if (goal !== 10'd40) begin nf++; $display("FAIL goal_l1 got %0d exp 40", goal); end
    n++; if (seconds_left !== 7'd3) begin nf++; $display("FAIL seconds_l1 got %0d exp 3", seconds_left); end
    score = 10'd40;
    ended = 1'b1;
    tick();
    ended = 1'b0;
    press();
    n++; if (game_state !== 3'd5) begin nf++; $display("FAIL win_state got %0d exp 5", game_state); end
    n++; if (total_score !== 12'd65) begin nf++; $display("FAIL win_total got %0d exp 65", total_score); end
    press();
    n++; if (game_state !== 3'd0) begin nf++; $display("FAIL win_title got %0d exp 0", game_state); end
    n++; if (level_clear !== 1'b1) begin nf++; $display("FAIL win_clear got %b exp 1", level_clear); end
  endtask

  task automatic test_fail();
    press();
    tick();
    n++; if (total_score !== 12'd0) begin nf++; $display("FAIL new_game_total got %0d exp 0", total_score); end
    score = 10'd19;
    ended = 1'b1;
    tick();
    ended = 1'b0;
    press();
    n++; if (game_state !== 3'd4) begin nf++; $display("FAIL gameover_state got %0d exp 4", game_state); end
    n++; if (total_score !== 12'd0) begin nf++; $display("FAIL gameover_total got %0d exp 0", total_score); end
    press();
    n++; if (game_state !== 3'd0) begin nf++; $display("FAIL gameover_title got %0d exp 0", game_state); end
  endtask

  task automatic test_back_to_back();
    press();
    tick();
    score = 10'd30;
    ended = 1'b1;
    enter = 1'b1;
    tick();
    ended = 1'b0;
    tick();
    tick();
    n++; if (game_state !== 3'd3) begin nf++; $display("FAIL simul_result got %0d exp 3", game_state); end
    press();
    n++; if (game_state !== 3'd1) begin nf++; $display("FAIL simul_advance got %0d exp 1", game_state); end
    n++; if (total_score !== 12'd30) begin nf++; $display("FAIL simul_total got %0d exp 30", total_score); end
    tick();
    press();
    n++; if (game_state !== 3'd2) begin nf++; $display("FAIL enter_in_play got %0d exp 2", game_state); end
    pulse_sof();
    pulse_sof();
    n++; if (seconds_left !== 7'd2) begin nf++; $display("FAIL l1_countdown got %0d exp 2", seconds_left); end
  endtask

  task automatic test_mid_reset();
    reset = 1'b1;
    tick();
    check_reset_values("mid_reset");
    reset = 1'b0;
    tick();
  endtask

  task automatic test_saturation();
    reset2 = 1'b1;
    tick();
    reset2 = 1'b0;
    tick();
    for (int l = 0; l < 8; l++) begin
      press2();
      tick();
      score2 = 10'd1023;
      ended2 = 1'b1;
      tick();
      ended2 = 1'b0;
      press2();
      if (l == 3) begin
        n++; if (s_total !== 12'd4092) begin nf++; $display("FAIL sat_l3 got %0d exp 4092", s_total); end
      end
      if (l == 4) begin
        n++; if (s_total !== 12'd4095) begin nf++; $display("FAIL sat_l4 got %0d exp 4095", s_total); end
      end
    end
    n++; if (s_state !== 3'd5) begin nf++; $display("FAIL sat_win got %0d exp 5", s_state); end
    n++; if (s_total !== 12'd4095) begin nf++; $display("FAIL sat_final got %0d exp 4095", s_total); end
    n++; if (s_level !== 3'd7) begin nf++; $display("FAIL sat_level got %0d exp 7", s_level); end
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_pass_win();
    test_fail();
    test_back_to_back();
    test_mid_reset();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n, nf);
    $finish;
  end
endmodule
